// File: rtl/stall_ctrl_pkg.sv
// Shared stall-bus types, stall masks and divider FSM encodings for the
// pipeline stall controller.
package stall_ctrl_pkg;

    localparam int STALL_W = 6;
    localparam int CNT_W   = 5;

    typedef logic [STALL_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Prefix masks: bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_IF   = 6'b000011;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        DIV_RUN  = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/stall_ctrl_div_seq.sv
// Divider sequencing FSM: start pulse, fixed iteration count, done handshake
// held while MEM is stalled so EX does not lose the quotient.
module div_seq
    import stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic div_req,
    input  logic div_signed_in,
    input  logic mem_stall,
    output logic div_start,
    output logic div_signed,
    output logic div_done,
    output logic ex_stop
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             signed_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_RUN;
            cnt      <= '0;
            signed_q <= 1'b0;
        end else begin
            case (state)
                DIV_RUN: begin
                    if (div_req) begin
                        state    <= DIV_BUSY;
                        cnt      <= CNT_LOAD;
                        signed_q <= div_signed_in;
                    end
                end
                DIV_BUSY: begin
                    if (cnt == '0) state <= DIV_DONE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                DIV_DONE: begin
                    if (!mem_stall) state <= DIV_RUN;
                end
                default: state <= DIV_RUN;
            endcase
        end
    end

    // Outputs are combinational so stage registers see them at the next edge.
    assign div_start  = !rst && (state == DIV_RUN) && div_req;
    assign div_done   = !rst && (state == DIV_DONE);
    assign div_signed = !rst && signed_q;
    assign ex_stop    = (!rst && (div_start || (state == DIV_BUSY) ||
                         ((state == DIV_DONE) && mem_stall))) ? STOP : NO_STOP;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges load-use, divider and SRAM wait sources
// into one prefix-mask stall bus where the deepest requesting stage wins.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_rs_used,
    input  logic               id_rt_used,
    input  logic               ex_we,
    input  logic [4:0]         ex_waddr,
    input  logic               ex_is_load,
    input  logic               ex_div_req,
    input  logic               ex_div_signed,
    input  logic               stallreq_if,
    input  logic               stallreq_mem,
    output logic [STALL_W-1:0] stall,
    output logic               div_start,
    output logic               div_signed,
    output logic               div_done
);

    logic ex_stop;
    logic load_use;

    div_seq #(.DIV_CYCLES(DIV_CYCLES)) u_div_seq (
        .clk           (clk),
        .rst           (rst),
        .div_req       (ex_div_req),
        .div_signed_in (ex_div_signed),
        .mem_stall     (stallreq_mem),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .div_done      (div_done),
        .ex_stop       (ex_stop)
    );

    // $zero is never a real dependency, so a load to it cannot stall ID.
    assign load_use = ex_is_load && ex_we && (ex_waddr != 5'd0) &&
                      ((id_rs_used && (id_rs == ex_waddr)) ||
                       (id_rt_used && (id_rt == ex_waddr)));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        stall = STALL_NONE;
        if (!rst) begin
            if (stallreq_if)      stall = stall | STALL_IF;
            if (load_use)         stall = stall | STALL_ID;
            if (ex_stop == STOP)  stall = stall | STALL_EX;
            if (stallreq_mem)     stall = stall | STALL_MEM;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed scoreboard bench for stall_ctrl: each step queues its expected
// outputs, then pops and compares them mid-cycle.
module tb_stall_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_IF   = 6'b000011;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;
    localparam logic [5:0] S_MEM  = 6'b011111;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_waddr;
    logic       id_rs_used, id_rt_used, ex_we, ex_is_load;
    logic       ex_div_req, ex_div_signed, stallreq_if, stallreq_mem;
    logic [5:0] stall;
    logic       div_start, div_signed, div_done;

    stall_ctrl #(.DIV_CYCLES(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_used    (id_rs_used),
        .id_rt_used    (id_rt_used),
        .ex_we         (ex_we),
        .ex_waddr      (ex_waddr),
        .ex_is_load    (ex_is_load),
        .ex_div_req    (ex_div_req),
        .ex_div_signed (ex_div_signed),
        .stallreq_if   (stallreq_if),
        .stallreq_mem  (stallreq_mem),
        .stall         (stall),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .div_done      (div_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [5:0] stall;
        logic       start;
        logic       done;
        logic       sgn;
        logic       sgn_chk;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Inputs are already driven; queue the expectation, compare at negedge,
    // then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [5:0] s, input logic st,
                        input logic dn, input logic sg, input logic sc);
        exp_t e;
        e.tag = tag; e.stall = s; e.start = st; e.done = dn; e.sgn = sg; e.sgn_chk = sc;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, ".stall"}, stall, e.stall);
        check({e.tag, ".div_start"}, {5'b0, div_start}, {5'b0, e.start});
        check({e.tag, ".div_done"}, {5'b0, div_done}, {5'b0, e.done});
        if (e.sgn_chk) check({e.tag, ".div_signed"}, {5'b0, div_signed}, {5'b0, e.sgn});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_waddr = '0;
        id_rs_used = 0; id_rt_used = 0; ex_we = 0; ex_is_load = 0;
        ex_div_req = 0; ex_div_signed = 0; stallreq_if = 0; stallreq_mem = 0;
    endtask

    initial begin
        // Reset with every request active.
        rst = 1;
        id_rs = 5'd8; id_rt = 5'd8; ex_waddr = 5'd8;
        id_rs_used = 1; id_rt_used = 1; ex_we = 1; ex_is_load = 1;
        ex_div_req = 1; ex_div_signed = 1; stallreq_if = 1; stallreq_mem = 1;
        step("rst0", S_NONE, 0, 0, 0, 1);
        step("rst1", S_NONE, 0, 0, 0, 1);
        rst = 0;
        clear_inputs();
        step("idle", S_NONE, 0, 0, 0, 1);

        // Load-use hazards.
        ex_is_load = 1; ex_we = 1; ex_waddr = 5'd8; id_rs = 5'd8; id_rs_used = 1;
        step("lu_rs", S_ID, 0, 0, 0, 0);
        ex_is_load = 0;
        step("lu_gone", S_NONE, 0, 0, 0, 0);
        ex_is_load = 1; ex_waddr = 5'd0; id_rs = 5'd0;
        step("lu_zero", S_NONE, 0, 0, 0, 0);
        ex_waddr = 5'd5; id_rt = 5'd5; id_rs = 5'd9; id_rt_used = 1;
        step("lu_rt", S_ID, 0, 0, 0, 0);
        id_rt_used = 0;
        step("lu_rt_unused", S_NONE, 0, 0, 0, 0);
        id_rt_used = 1; ex_we = 0;
        step("lu_no_we", S_NONE, 0, 0, 0, 0);

        // Priority between sources.
        ex_we = 1; stallreq_if = 1;
        step("pri_if_lu", S_ID, 0, 0, 0, 0);
        stallreq_mem = 1;
        step("pri_mem_lu", S_MEM, 0, 0, 0, 0);
        ex_is_load = 0;
        step("pri_mem_if", S_MEM, 0, 0, 0, 0);
        stallreq_mem = 0;
        step("pri_if", S_IF, 0, 0, 0, 0);
        clear_inputs();

        // Signed divide, clean completion.
        ex_div_req = 1; ex_div_signed = 1;
        step("div1_start", S_EX, 1, 0, 0, 0);
        ex_div_signed = 0;
        for (int i = 1; i <= 32; i++) step("div1_busy", S_EX, 0, 0, 1, 1);
        step("div1_done", S_NONE, 0, 1, 1, 1);
        ex_div_req = 0;
        step("div1_idle", S_NONE, 0, 0, 1, 1);

        // Unsigned divide, MEM stalls during BUSY and in DONE.
        ex_div_req = 1; ex_div_signed = 0;
        step("div2_start", S_EX, 1, 0, 0, 0);
        for (int i = 1; i <= 32; i++) begin
            stallreq_mem = (i >= 5 && i <= 7);
            step("div2_busy", (i >= 5 && i <= 7) ? S_MEM : S_EX, 0, 0, 0, 1);
        end
        stallreq_mem = 1;
        for (int i = 0; i < 3; i++) step("div2_done_mem", S_MEM, 0, 1, 0, 1);
        stallreq_mem = 0;
        step("div2_done", S_NONE, 0, 1, 0, 1);
        ex_div_req = 0;
        step("div2_idle", S_NONE, 0, 0, 0, 1);

        // Reset mid-divide aborts; a new request restarts from a full count.
        ex_div_req = 1; ex_div_signed = 1;
        step("div3_start", S_EX, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) step("div3_busy", S_EX, 0, 0, 1, 1);
        rst = 1;
        step("div3_rst", S_NONE, 0, 0, 0, 1);
        rst = 0; ex_div_req = 0;
        for (int i = 0; i < 40; i++) step("div3_aborted", S_NONE, 0, 0, 0, 1);
        ex_div_req = 1; ex_div_signed = 1;
        step("div4_start", S_EX, 1, 0, 0, 0);
        for (int i = 1; i <= 32; i++) step("div4_busy", S_EX, 0, 0, 1, 1);
        step("div4_done", S_NONE, 0, 1, 1, 1);
        ex_div_req = 0;
        step("div4_idle", S_NONE, 0, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall controller for the 5-stage MIPS core. Combines stall sources into the shared stall bus consumed by PC, IF, ID, EX, MEM and WB:
- load-use hazards detected at ID,
- multi-cycle divide occupancy in EX,
- instruction/data SRAM wait requests.

Owns the divider sequencing FSM (start pulse, cycle count, done pulse), so EX stays a pure datapath.

## Interface
Parameters:
- DIV_CYCLES, 32, iterations of the radix-2 divider; legal range ≥ 2.

Ports:
- clk  in  1  core clock; everything is sampled on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- ex_we  in  1  EX instruction writes the register file.
- ex_waddr  in  5  EX destination register.
- ex_is_load  in  1  EX instruction is lb/lbu/lh/lhu/lw.
- ex_div_req  in  1  EX holds div/divu.
- ex_div_signed  in  1  EX instruction is div, not divu.
- stallreq_if  in  1  instruction SRAM not ready.
- stallreq_mem  in  1  data SRAM not ready.
- stall  out  `StallBus (6)  bit k = `Stop holds stage k; order is 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- div_start  out  1  one-cycle pulse that launches the divider.
- div_signed  out  1  signedness latched at div_start.
- div_done  out  1  divider result valid for EX to capture.

## Operation
- Stall encoding is always a prefix mask. The legal values are 000000, 000011 (IF), 000111 (ID), 001111 (EX) and 011111 (MEM).
- The receiving stage inserts a bubble when stall[k] = Stop and stall[k+1] = NoStop.
- Source levels:
  - stallreq_mem → 011111.
  - div FSM in START or BUSY, or in DONE with stallreq_mem asserted → 001111.
  - load-use → 000111.
  - stallreq_if → 000011.
- stall is the OR of all active source masks, so the deepest stage wins.
- Load-use condition: ex_is_load & ex_we & ex_waddr ≠ 0 & ((id_rs_used & id_rs == ex_waddr) | (id_rt_used & id_rt == ex_waddr)).
- Load-use is purely combinational and produces one bubble per load; after one bubble the load has left EX.
- Div FSM states are RUN, BUSY and DONE, held in a 5-bit down-counter cnt plus the state register.
  - RUN: on ex_div_req, assert div_start, latch div_signed ← ex_div_signed, load cnt ← DIV_CYCLES−1, go to BUSY. stall includes 001111 in this cycle.
  - BUSY: if cnt = 0 go to DONE, else cnt ← cnt−1. stall includes 001111.
  - DONE: div_done = 1 and EX stall is released.
    - If stallreq_mem = 0, go to RUN.
    - If stallreq_mem = 1, stay in DONE with div_done held, so EX keeps the result.
- A request in RUN is never re-triggered by the same instruction, because DONE always advances EX before the FSM returns to RUN.
- The divider keeps counting during MEM stalls. The FSM does not pause in BUSY.
- During rst:
  - stall = 000000, div_start = 0, div_done = 0, div_signed = 0.
  - State ← RUN, cnt ← 0.
- rst asserted mid-divide aborts the operation. No div_done is produced.

## Timing
- Outputs stall, div_start and div_done are combinational from the registered state and current inputs. They must settle within the same cycle, because stage registers use them at the next edge.
- Divide accepted in RUN at cycle T:
  - div_start high at T.
  - BUSY during T+1 … T+DIV_CYCLES.
  - DONE at T+DIV_CYCLES+1, when EX advances.
  - 001111 asserted for DIV_CYCLES+1 cycles.
- Load-use adds exactly 1 bubble. Any SRAM stall adds stall cycles equal to the request length. Outputs have no registered delay.
- Simultaneous load-use and stallreq_mem: 011111. The load-use mask remains implied, and the condition is re-evaluated each cycle.

## Structure
- Add to lib/defines.vh:
  - `StallBus.
  - `Stop / `NoStop.
  - Stall mask constants STALL_IF, STALL_ID, STALL_EX, STALL_MEM.
  - Div FSM state encodings.
- One sub-module, div_seq: the RUN/BUSY/DONE FSM and counter.
- stall_ctrl instantiates div_seq plus the combinational hazard and merge logic.

## Test plan
- Reset: rst=1 for 2 cycles with all requests high → stall=000000, div_start=0, div_done=0. After release, state is RUN.
- Load-use: ex_is_load=1, ex_we=1, ex_waddr=8, id_rs=8, id_rs_used=1 → stall=000111 for 1 cycle. With ex_waddr=0 → stall=000000.
- Divide: ex_div_req=1, ex_div_signed=1 at T → div_start at T, div_signed=1, stall=001111 for cycles T … T+32 (DIV_CYCLES=32), div_done and stall=000000 at T+33.
- DONE under MEM stall: stallreq_mem=1 at T+33 for 3 cycles → stall=011111, div_done held high for 4 cycles, then RUN.
- Reset mid-divide: rst at T+10 → stall=000000, div_done never pulses. A new ex_div_req afterwards restarts from a full count.
- Priority: stallreq_if=1 with load-use active → stall=000111. Adding stallreq_mem=1 → stall=011111.
